// File: rtl/frac_div_pkg.sv
// Shared defaults and types for the fractional-N clock divider.
package frac_div_pkg;

  localparam int DEF_N_W   = 8;
  localparam int DEF_F_W   = 16;
  localparam int DEF_N_RST = 4;
  localparam int MIN_MOD   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_t;

endpackage

// File: rtl/sdm_acc.sv
// First-order sigma-delta accumulator: adds F once per output period and
// reports the overflow carry that stretches that period by one cycle.
module sdm_acc
  import frac_div_pkg::*;
#(
  parameter int F_W = DEF_F_W
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           step,
  input  logic [F_W-1:0] f,
  output logic           carry
);

  logic [F_W-1:0] acc;
  logic [F_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, f};
  assign carry = sum[F_W];

  always_ff @(posedge clk) begin
    if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[F_W-1:0];
    end
  end

endmodule

// File: rtl/frac_n_divider.sv
// Fractional-N clock divider: period counter, shadow-config handshake and
// output shaping around a first-order accumulator.
//
// state   | meaning
// ST_IDLE | after reset or while disabled; next enabled cycle is a boundary
// ST_RUN  | dividing; boundary when the counter reaches M-1
module frac_n_divider
  import frac_div_pkg::*;
#(
  parameter int N_W   = DEF_N_W,
  parameter int F_W   = DEF_F_W,
  parameter int N_RST = DEF_N_RST
) (
  input  logic           in,
  input  logic           rst,
  input  logic           enable,
  input  logic [N_W-1:0] n_int,
  input  logic [F_W-1:0] frac,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  output logic           out,
  output logic           sync
);

  // One extra bit so M = 2^N_W (max N plus carry) fits.
  localparam int CNT_W = N_W + 1;

  div_state_t     state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] m_q, m_d;
  logic [CNT_W-1:0] m_new, n_clamp, half;
  logic [N_W-1:0]   n_act, sh_n, n_eff;
  logic [F_W-1:0]   f_act, sh_f, f_eff;
  logic             pend;
  logic             boundary;
  logic             carry;
  logic             out_d, sync_d;

  assign cfg_ready = ~pend;

  // A pending config takes effect in the period that starts at the boundary.
  assign n_eff = pend ? sh_n : n_act;
  assign f_eff = pend ? sh_f : f_act;

  sdm_acc #(.F_W(F_W)) u_acc (
    .clk   (in),
    .clear (rst),
    .step  (boundary),
    .f     (f_eff),
    .carry (carry)
  );

  always_ff @(posedge in) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    k_d      = '0;
    m_d      = m_q;
    n_clamp  = (n_eff < N_W'(MIN_MOD)) ? CNT_W'(MIN_MOD) : {1'b0, n_eff};
    m_new    = n_clamp + {{N_W{1'b0}}, carry};
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      state_d  = ST_RUN;
      boundary = (state_q == ST_IDLE) || (k_q == m_q - CNT_W'(1));
      if (boundary) begin
        m_d = m_new;
      end else begin
        k_d = k_q + CNT_W'(1);
      end
    end
    half   = (m_d + CNT_W'(1)) >> 1;
    out_d  = enable && (k_d < half);
    sync_d = boundary;
  end

  always_ff @(posedge in) begin
    if (rst) begin
      k_q   <= '0;
      m_q   <= CNT_W'(MIN_MOD);
      out   <= 1'b0;
      sync  <= 1'b0;
      n_act <= N_W'(N_RST);
      f_act <= '0;
      sh_n  <= '0;
      sh_f  <= '0;
      pend  <= 1'b0;
    end else begin
      k_q  <= k_d;
      m_q  <= m_d;
      out  <= out_d;
      sync <= sync_d;
      // Apply and capture are exclusive: capture needs pend low, apply needs it high.
      if (boundary && pend) begin
        n_act <= sh_n;
        f_act <= sh_f;
        pend  <= 1'b0;
      end else if (cfg_valid && !pend) begin
        sh_n <= n_int;
        sh_f <= frac;
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frac_n_divider.sv
// Directed bench for frac_n_divider (N_W=8, F_W=4, N_RST=4).
module tb_frac_n_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] n_int = '0;
  logic [3:0] frac = '0;
  logic       cfg_ready, out, sync;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frac_n_divider #(.N_W(8), .F_W(4), .N_RST(4)) dut (
    .in        (clk),
    .rst       (rst),
    .enable    (enable),
    .n_int     (n_int),
    .frac      (frac),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .out       (out),
    .sync      (sync)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sync(input string tag);
    int n = 0;
    while (sync !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_sync"}, {31'd0, sync}, 32'd1);
  endtask

  // Starts on a sync cycle, ends on the next one.
  task automatic period(input string tag, input int ep, input int eh);
    int p = 0;
    int h = 0;
    do begin
      if (out === 1'b1) h++;
      p++;
      tick();
    end while (sync !== 1'b1 && p < 300);
    check({tag, "_per"}, p, ep);
    check({tag, "_hi"}, h, eh);
  endtask

  task automatic cfg(input int n, input int f);
    n_int     = 8'(n);
    frac      = 4'(f);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int p;

    tick();
    tick();
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_sync", {31'd0, sync}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);

    rst = 1'b0;
    enable = 1'b1;
    tick();
    check("first_boundary", {31'd0, sync}, 32'd1);
    period("n4a", 4, 2);
    period("n4b", 4, 2);

    tick();
    cfg(5, 0);
    check("n5_ready_low", {31'd0, cfg_ready}, 32'd0);
    wait_sync("n5");
    check("n5_ready_back", {31'd0, cfg_ready}, 32'd1);
    period("n5a", 5, 3);
    period("n5b", 5, 3);

    cfg(6, 0);
    wait_sync("n6");
    period("n6", 6, 3);

    // N=10 requested mid-period; a second request while busy must be dropped.
    tick();
    cfg(10, 0);
    check("n10_ready_low", {31'd0, cfg_ready}, 32'd0);
    n_int = 8'd3;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("n10_ready_still_low", {31'd0, cfg_ready}, 32'd0);
    p = 3;
    while (sync !== 1'b1 && p < 50) begin
      tick();
      p++;
    end
    check("n6_finish", p, 6);
    period("n10a", 10, 5);
    period("n10b", 10, 5);

    cfg(0, 0);
    wait_sync("n0");
    period("n0a", 2, 1);
    period("n0b", 2, 1);

    cfg(8, 4);
    wait_sync("frac");
    period("f1", 8, 4);
    period("f2", 8, 4);
    period("f3", 8, 4);
    period("f4", 9, 5);

    // acc is 4 here; pause mid-period and resume
    tick();
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("dis_out", {31'd0, out}, 32'd0);
    check("dis_sync", {31'd0, sync}, 32'd0);
    tick();
    tick();
    enable = 1'b1;
    tick();
    check("en_boundary", {31'd0, sync}, 32'd1);
    period("e1", 8, 4);
    period("e2", 8, 4);
    period("e3", 9, 5);

    cfg(7, 0);
    tick();
    check("pend_before_rst", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_out", {31'd0, out}, 32'd0);
    check("mid_rst_sync", {31'd0, sync}, 32'd0);
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b0;
    tick();
    check("rst_restart", {31'd0, sync}, 32'd1);
    period("r1", 4, 2);
    period("r2", 4, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frac_n_divider.md
FRAC_N_DIVIDER -- requirements
Module: frac_n_divider

Interface
REQ-001 The block SHALL have parameter N_W, default 8, meaning the integer modulus width.
REQ-002 The block SHALL have parameter F_W, default 16, meaning the fractional word width.
REQ-003 The block SHALL have parameter N_RST, default 4, meaning the integer modulus loaded at reset.
REQ-004 Port in, input, 1: divider input clock; single clock domain, all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port enable, input, 1: run control; low freezes division.
REQ-007 Port n_int, input, N_W: requested integer modulus N.
REQ-008 Port frac, input, F_W: requested fractional part F; fraction = F/2^F_W.
REQ-009 Port cfg_valid, input, 1: config request; n_int and frac are sampled with it.
REQ-010 Port cfg_ready, output, 1: shadow register free; a new config is accepted.
REQ-011 Port out, output, 1: divided clock, registered, near-50% duty.
REQ-012 Port sync, output, 1: one-cycle registered pulse on the first input cycle of each output period.

Function
REQ-013 Each output period SHALL last M input cycles: M = max(N_act,2) + c, where c is the accumulator carry for that period.
REQ-014 Accumulator: at each period boundary, sum = acc + F_act (F_W+1 bits); c = sum[F_W]; acc <= sum[F_W-1:0].
REQ-015 The period counter SHALL be N_W+1 bits wide, so M = 2^N_W (N = 2^N_W-1, c = 1) has no overflow.
REQ-016 Within a period, k runs 0..M-1; out = 1 for k < ceil(M/2), else 0; sync = 1 only at k = 0.
REQ-017 A period boundary is the cycle that computes k = 0; the next period's M is fixed there and SHALL NOT change mid-period.
REQ-018 Handshake: when cfg_valid = 1 and cfg_ready = 1 on an edge, n_int and frac go to the shadow register, pend sets, and cfg_ready drops on the next cycle.
REQ-019 A pending config SHALL be applied at the first boundary strictly after the capture cycle; cfg_ready re-asserts the cycle after that boundary.
REQ-020 cfg_valid while cfg_ready = 0 SHALL be ignored, with no queuing.
REQ-021 When a config is applied, acc SHALL be retained, not cleared.
REQ-022 With frac = 0, c SHALL always be 0, giving pure integer division.
REQ-023 n_int < 2 SHALL be clamped to 2, so out never stalls.
REQ-024 enable = 0 SHALL:
  - force out = 0 and sync = 0;
  - clear the counter;
  - retain acc, active config and shadow config;
  - keep the handshake operating.
REQ-025 The first enabled cycle after enable = 0 or after reset SHALL be a period boundary (k = 0).

Reset
REQ-026 With rst = 1 at an edge, next-cycle values SHALL be: out = 0, sync = 0, counter = 0, acc = 0, N_act = N_RST, F_act = 0, pend = 0, cfg_ready = 1.
REQ-027 Reset SHALL override enable and cfg_valid in the same cycle; a mid-period reset aborts the period and discards any pending config.

Structure
REQ-028 Package frac_div_pkg SHALL hold:
  - default N_W, F_W and N_RST;
  - constant MIN_MOD = 2.
REQ-029 Sub-module sdm_acc SHALL hold the first-order accumulator, with ports: step strobe, F, carry out, and synchronous clear.
REQ-030 The counter, config handshake and output shaping SHALL be in frac_n_divider.

Verification
REQ-031 N = 4, F = 0, enable = 1 -> out period 4, 2 high / 2 low; sync every 4 cycles.
REQ-032 N = 5, F = 0 -> out 3 high / 2 low, period 5.
REQ-033 F_W = 4, N = 8, F = 4 -> period sequence 8, 8, 8, 9 repeating; 33 cycles per 4 periods.
REQ-034 Config N = 6 -> N = 10 issued mid-period:
  - current period completes at 6;
  - cfg_ready stays low until the boundary;
  - the next period is 10.
REQ-035 n_int = 0 -> period 2, out alternating 1,0.
REQ-036 rst pulsed mid-period with a config pending -> outputs 0 and cfg_ready = 1 next cycle; the pending config is lost; division restarts with N = N_RST.
